// File: rtl/rv32_fetch_queue_if.sv
// rv32_fetch_queue_if: redirect, instruction-memory and decode-side signals of the fetch queue.
interface rv32_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   mem_req_valid;
  logic [XLEN-1:0]        mem_req_addr;
  logic                   mem_req_done;
  logic [XLEN-1:0]        mem_rdata;
  logic                   out_valid;
  logic [XLEN-1:0]        out_pc;
  logic [XLEN-1:0]        out_instr;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] occupancy;
  modport master (
    input  redirect_valid, redirect_pc, mem_req_done, mem_rdata, out_ready,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr, occupancy
  );
  modport slave (
    output redirect_valid, redirect_pc, mem_req_done, mem_rdata, out_ready,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr, occupancy
  );
endinterface

// File: rtl/rv32_fetch_queue.sv
// rv32_fetch_queue: DEPTH-entry {pc, instr} prefetch queue between imem and decode.
// Define FETCH_QUEUE_BYPASS_EN to present a response to an empty queue in its done cycle.
module rv32_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  rv32_fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d, redir_pc;
  logic            req_valid_q, req_valid_d, discard_q, discard_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic            done, byp, push, qpop, issue;
  assign redir_pc = fq.redirect_pc & ~XLEN'(3);
  assign done = state_q == BUSY && fq.mem_req_done;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = done && occ_q == '0 && !discard_q && !fq.redirect_valid;
`else
  assign byp = 1'b0;
`endif
  assign fq.out_valid = occ_q != '0 || byp;
  assign fq.out_pc = byp ? req_addr_q : pc_mem[rd_q];
  assign fq.out_instr = byp ? fq.mem_rdata : instr_mem[rd_q];
  assign fq.mem_req_valid = req_valid_q;
  assign fq.mem_req_addr = req_addr_q;
  assign fq.occupancy = occ_q;
  assign qpop = occ_q != '0 && fq.out_ready && !fq.redirect_valid;
  assign push = done && !discard_q && !fq.redirect_valid && !(byp && fq.out_ready);
  always_comb begin
    occ_d = fq.redirect_valid ? '0 : occ_q + CW'(push) - CW'(qpop);
    rd_d = fq.redirect_valid ? '0 : rd_q + AW'(qpop);
    wr_d = fq.redirect_valid ? '0 : wr_q + AW'(push);
    fetch_pc_d = fq.redirect_valid ? redir_pc : (done && !discard_q) ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    discard_d = done ? 1'b0 : discard_q || (fq.redirect_valid && state_q == BUSY);
    // a request is issued only when its response already has a free slot after this edge
    issue = (state_q == IDLE || done) && occ_d < FULL;
    state_d = issue ? BUSY : done ? IDLE : state_q;
    req_valid_d = issue ? 1'b1 : done ? 1'b0 : req_valid_q;
    req_addr_d = issue ? fetch_pc_d : req_addr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_valid_q <= 1'b0;
      discard_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      occ_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      req_valid_q <= req_valid_d;
      discard_q <= discard_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q] <= req_addr_q;
      instr_mem[wr_q] <= fq.mem_rdata;
    end
  end
endmodule

// File: tb/tb_rv32_fetch_queue.sv
// tb_rv32_fetch_queue: directed checks of fetch, fill/backpressure, redirects, wrap and bypass latency.
module tb_rv32_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic auto_mem = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  rv32_fetch_queue_if #(.DEPTH(4), .XLEN(32)) fq ();
  rv32_fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .fq(fq.master)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      fq.mem_req_done = fq.mem_req_valid;
      fq.mem_rdata = f(fq.mem_req_addr);
    end
    #1;
  endtask
  initial begin
    fq.redirect_valid = 1'b0;
    fq.redirect_pc = '0;
    fq.mem_req_done = 1'b0;
    fq.mem_rdata = '0;
    fq.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_occ", 32'(fq.occupancy), 0);
    chk("rst_oval", 32'(fq.out_valid), 0);
    chk("rst_rval", 32'(fq.mem_req_valid), 0);
    chk("rst_addr", fq.mem_req_addr, 0);
    reset = 1'b0;
    tick();
    chk("t1_rval", 32'(fq.mem_req_valid), 1);
    chk("t1_addr", fq.mem_req_addr, 0);
    chk("t1_oval0", 32'(fq.out_valid), 32'(BYP));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_oval", 32'(fq.out_valid), 1);
      chk("t1_pc", fq.out_pc, 32'(4 * (i + int'(BYP))));
      chk("t1_instr", fq.out_instr, f(32'(4 * (i + int'(BYP)))));
      chk("t1_occ", 32'(fq.occupancy), BYP ? 0 : 1);
    end
    fq.out_ready = 1'b0;
    for (int k = 0; k < 20 && fq.occupancy != 3'd4; k++) tick();
    chk("t2_occ_full", 32'(fq.occupancy), 4);
    chk("t2_rval_off", 32'(fq.mem_req_valid), 0);
    chk("t2_head", fq.out_pc, BYP ? 32'h10 : 32'hC);
    fq.out_ready = 1'b1;
    tick();
    fq.out_ready = 1'b0;
    chk("t2_occ_pop", 32'(fq.occupancy), 3);
    chk("t2_rval_on", 32'(fq.mem_req_valid), 1);
    chk("t2_addr", fq.mem_req_addr, BYP ? 32'h20 : 32'h1C);
    chk("t2_head2", fq.out_pc, BYP ? 32'h14 : 32'h10);
    tick();
    chk("t2_occ_refill", 32'(fq.occupancy), 4);
    chk("t2_rval_off2", 32'(fq.mem_req_valid), 0);
    auto_mem = 1'b0;
    fq.mem_req_done = 1'b0;
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 32'h10;
    tick();
    chk("t3_occ", 32'(fq.occupancy), 0);
    chk("t3_oval", 32'(fq.out_valid), 0);
    chk("t3_rval", 32'(fq.mem_req_valid), 1);
    chk("t3_addr", fq.mem_req_addr, 32'h10);
    fq.redirect_pc = 32'h203;
    tick();
    fq.redirect_valid = 1'b0;
    chk("t3_hold1", fq.mem_req_addr, 32'h10);
    tick();
    chk("t3_hold2", fq.mem_req_addr, 32'h10);
    chk("t3_hold_v", 32'(fq.mem_req_valid), 1);
    fq.mem_req_done = 1'b1;
    fq.mem_rdata = f(32'h10);
    #1;
    chk("t3_drop_comb", 32'(fq.out_valid), 0);
    tick();
    chk("t3_newaddr", fq.mem_req_addr, 32'h200);
    chk("t3_drop_occ", 32'(fq.occupancy), 0);
    chk("t3_drop_oval", 32'(fq.out_valid), 0);
    fq.mem_rdata = f(32'h200);
    tick();
    chk("t3_occ1", 32'(fq.occupancy), 1);
    chk("t3_pc", fq.out_pc, 32'h200);
    chk("t3_instr", fq.out_instr, f(32'h200));
    chk("t3_next", fq.mem_req_addr, 32'h204);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 32'h20;
    fq.mem_rdata = f(32'h204);
    tick();
    fq.redirect_valid = 1'b0;
    chk("t4a_occ", 32'(fq.occupancy), 0);
    chk("t4a_addr", fq.mem_req_addr, 32'h20);
    fq.mem_rdata = f(32'h20);
    tick();
    fq.mem_rdata = f(32'h24);
    tick();
    chk("t4_occ2", 32'(fq.occupancy), 2);
    chk("t4_head", fq.out_pc, 32'h20);
    fq.mem_rdata = f(32'h28);
    fq.out_ready = 1'b1;
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 32'h301;
    tick();
    fq.redirect_valid = 1'b0;
    fq.out_ready = 1'b0;
    fq.mem_req_done = 1'b0;
    chk("t4_occ0", 32'(fq.occupancy), 0);
    chk("t4_oval", 32'(fq.out_valid), 0);
    chk("t4_rval", 32'(fq.mem_req_valid), 1);
    chk("t4_addr", fq.mem_req_addr, 32'h300);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 32'hFFFF_FFFE;
    tick();
    fq.redirect_valid = 1'b0;
    chk("t5_hold", fq.mem_req_addr, 32'h300);
    fq.mem_req_done = 1'b1;
    fq.mem_rdata = f(32'h300);
    tick();
    chk("t5_addr_fc", fq.mem_req_addr, 32'hFFFF_FFFC);
    chk("t5_occ0", 32'(fq.occupancy), 0);
    fq.mem_rdata = f(32'hFFFF_FFFC);
    tick();
    fq.mem_req_done = 1'b0;
    chk("t5_wrap", fq.mem_req_addr, 32'h0);
    chk("t5_pc", fq.out_pc, 32'hFFFF_FFFC);
    chk("t5_occ1", 32'(fq.occupancy), 1);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 32'h40;
    fq.mem_req_done = 1'b1;
    fq.mem_rdata = f(32'h0);
    tick();
    fq.redirect_valid = 1'b0;
    chk("t6_addr", fq.mem_req_addr, 32'h40);
    chk("t6_occ0", 32'(fq.occupancy), 0);
    fq.mem_rdata = f(32'h40);
    fq.out_ready = 1'b1;
    #1;
    chk("t6_oval_c", 32'(fq.out_valid), 32'(BYP));
    chk("t6_pc_c", fq.out_valid ? fq.out_pc : 32'h0, BYP ? 32'h40 : 32'h0);
    tick();
    fq.mem_req_done = 1'b0;
    #1;
    chk("t6_occ", 32'(fq.occupancy), BYP ? 0 : 1);
    chk("t6_oval_c1", 32'(fq.out_valid), 32'(!BYP));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_rval", 32'(fq.mem_req_valid), 0);
    chk("t7_occ", 32'(fq.occupancy), 0);
    chk("t7_addr", fq.mem_req_addr, 0);
    chk("t7_oval", 32'(fq.out_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
